uart_tx_arbiter: RTL

Round-robin arbiter that shares one UART transmitter between `NUM_REQ` byte-stream requesters. The block sits between the client logic and the transmitter's start/busy handshake. It grants one requester at a time and launches that requester's bytes one by one. It releases the grant at the end of a burst, or after `MAX_BURST` bytes, so that no requester starves the others.

---
 rtl/uart_tx_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART transmitter among NUM_REQ byte streams.
// Define UART_TX_SOURCE_TAG_EN to prefix every grant with the header byte 8'hF0 | grant_id.
module uart_tx_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int MAX_BURST = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [8*NUM_REQ-1:0]       req_data,
   input  logic [NUM_REQ-1:0]         req_last,
   output logic [NUM_REQ-1:0]         req_ack,
   output logic [7:0]                 tx_data,
   output logic                       tx_start,
   input  logic                       tx_busy,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       grant_valid
);

   localparam int unsigned IDW       = $clog2(NUM_REQ);
   localparam int unsigned NREQ      = NUM_REQ;
   localparam logic [7:0]  BURST_MAX = 8'(MAX_BURST);

   typedef enum logic [2:0] {
      IDLE,
      ARB,
`ifdef UART_TX_SOURCE_TAG_EN
      TAG,
`endif
      SEND,
      WAIT_BUSY,
      WAIT_DONE
   } state_t;

   state_t         state;
   state_t         rel_state;
   logic [IDW-1:0] last_grant;
   logic [IDW-1:0] arb_sel;
   logic           arb_found;
   int unsigned    rr_idx;
   logic [7:0]     byte_cnt;
   logic [2:0]     tmo_cnt;
   logic           last_flag;
   logic           cur_req;
   logic           cur_last;
   logic [7:0]     cur_data;
`ifdef UART_TX_SOURCE_TAG_EN
   logic           tag_phase;
`endif

   assign cur_req   = req[grant_id];
   assign cur_last  = req_last[grant_id];
   assign cur_data  = req_data[{grant_id, 3'b000} +: 8];
   assign rel_state = (|req) ? ARB : IDLE;

   // Search starts one past the previous winner so every requester gets a turn.
   always_comb begin
      arb_sel   = last_grant;
      arb_found = 1'b0;
      rr_idx    = 0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         rr_idx = (32'(last_grant) + k) % NREQ;
         if (!arb_found && req[rr_idx[IDW-1:0]]) begin
            arb_sel   = rr_idx[IDW-1:0];
            arb_found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         last_grant  <= IDW'(NUM_REQ - 1);
         byte_cnt    <= '0;
         tmo_cnt     <= '0;
         last_flag   <= 1'b0;
         req_ack     <= '0;
         tx_data     <= '0;
         tx_start    <= 1'b0;
         grant_id    <= '0;
         grant_valid <= 1'b0;
`ifdef UART_TX_SOURCE_TAG_EN
         tag_phase   <= 1'b0;
`endif
      end else begin
         tx_start <= 1'b0;
         req_ack  <= '0;
         case (state)
            IDLE: begin
               if (|req) state <= ARB;
            end
            // Holding in ARB while tx_busy is high covers a byte left in flight by a reset.
            ARB: begin
               if (!arb_found) begin
                  state <= IDLE;
               end else if (!tx_busy) begin
                  grant_id    <= arb_sel;
                  last_grant  <= arb_sel;
                  grant_valid <= 1'b1;
                  byte_cnt    <= '0;
`ifdef UART_TX_SOURCE_TAG_EN
                  state       <= TAG;
`else
                  state       <= SEND;
`endif
               end
            end
`ifdef UART_TX_SOURCE_TAG_EN
            TAG: begin
               if (!tx_busy) begin
                  tx_data   <= 8'hF0 | 8'(grant_id);
                  tx_start  <= 1'b1;
                  tag_phase <= 1'b1;
                  tmo_cnt   <= '0;
                  state     <= WAIT_BUSY;
               end
            end
`endif
            SEND: begin
               if (!cur_req) begin
                  grant_valid <= 1'b0;
                  state       <= rel_state;
               end else if (!tx_busy) begin
                  tx_data           <= cur_data;
                  tx_start          <= 1'b1;
                  req_ack[grant_id] <= 1'b1;
                  last_flag         <= cur_last;
                  if (byte_cnt != 8'hFF) byte_cnt <= byte_cnt + 8'd1;
                  tmo_cnt           <= '0;
                  state             <= WAIT_BUSY;
               end
            end
            WAIT_BUSY: begin
               if (tx_busy || tmo_cnt == 3'd7) state <= WAIT_DONE;
               else tmo_cnt <= tmo_cnt + 3'd1;
            end
            WAIT_DONE: begin
               if (!tx_busy) begin
`ifdef UART_TX_SOURCE_TAG_EN
                  if (tag_phase) begin
                     tag_phase <= 1'b0;
                     if (!cur_req) begin
                        grant_valid <= 1'b0;
                        state       <= rel_state;
                     end else begin
                        state <= SEND;
                     end
                  end else
`endif
                  if (last_flag || byte_cnt == BURST_MAX || !cur_req) begin
                     grant_valid <= 1'b0;
                     state       <= rel_state;
                  end else begin
                     state <= SEND;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
